// File: rtl/audio_pkg.sv
// Shared audio definitions: sample/gain widths, 16-bit limits, mixer FSM states
// and the signed 16-bit clamp used by the mixer and DAC-side blocks.
package audio_pkg;

   localparam int SAMPLE_W = 16;
   localparam int GAIN_W   = 4;
   localparam int PROD_W   = SAMPLE_W + GAIN_W;

   localparam logic [15:0] S16_MAX   = 16'h7FFF;
   localparam logic [15:0] S16_MIN   = 16'h8000;
   localparam int          S16_MAX_I = 32767;
   localparam int          S16_MIN_I = -32768;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPT,
      ST_ACC,
      ST_SAT,
      ST_OUT
   } mix_state_t;

   function automatic logic [15:0] sat16(input logic signed [31:0] v);
      if (v > S16_MAX_I) return S16_MAX;
      if (v < S16_MIN_I) return S16_MIN;
      return v[15:0];
   endfunction

endpackage

// File: rtl/mix_mac.sv
// One channel step of the mixer: signed sample times unsigned gain, added into
// a wide accumulator that cannot wrap for the configured channel count.
module mix_mac
   import audio_pkg::*;
#(
   parameter int ACC_W = 23
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [GAIN_W-1:0]   gain,
   output logic [ACC_W-1:0]    acc
);

   // 16s x 4u always fits in 20 signed bits, so the truncated product is exact.
   logic signed [PROD_W-1:0] prod;

   assign prod = $signed({{GAIN_W{sample[SAMPLE_W-1]}}, sample}) *
                 $signed({{SAMPLE_W{1'b0}}, gain});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/audio_mixer.sv
// Per-frame stereo mixer: on each lrck rise, snapshot NCH sources, gain and sum
// them through one shared MAC per side, saturate, and present stable L/R words.
module audio_mixer
   import audio_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int GAIN_SH = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  lrck,
   input  logic [16*NCH-1:0]     src_l,
   input  logic [16*NCH-1:0]     src_r,
   input  logic [4*NCH-1:0]      gain,
   input  logic                  mute,
   output logic [15:0]           left,
   output logic [15:0]           right,
   output logic                  sample_stb,
   output logic                  overrun
);

   localparam int CH_W  = $clog2(NCH);
   localparam int ACC_W = PROD_W + CH_W + 1;

   mix_state_t state, state_next;

   logic                lrck_q;
   logic                start;
   logic [CH_W-1:0]     ch;
   logic [SAMPLE_W-1:0] snap_l [NCH];
   logic [SAMPLE_W-1:0] snap_r [NCH];
   logic [GAIN_W-1:0]   snap_g [NCH];
   logic                snap_mute;
   logic [ACC_W-1:0]    acc_l, acc_r;
   logic signed [ACC_W-1:0] sh_l, sh_r;
   logic [15:0]         mix_l, mix_r;

   assign start = lrck & ~lrck_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_CAPT;
         ST_CAPT: state_next = ST_ACC;
         ST_ACC:  if (ch == CH_W'(NCH - 1)) state_next = ST_SAT;
         ST_SAT:  state_next = ST_OUT;
         ST_OUT:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lrck_q     <= 1'b0;
         ch         <= '0;
         snap_mute  <= 1'b0;
         left       <= '0;
         right      <= '0;
         sample_stb <= 1'b0;
         overrun    <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            snap_l[k] <= '0;
            snap_r[k] <= '0;
            snap_g[k] <= '0;
         end
      end else begin
         lrck_q     <= lrck;
         sample_stb <= 1'b0;
         // Any new frame edge outside IDLE (OUT included) is dropped and flagged.
         if (start && state != ST_IDLE) overrun <= 1'b1;
         if (state == ST_CAPT) begin
            ch        <= '0;
            snap_mute <= mute;
            for (int k = 0; k < NCH; k++) begin
               snap_l[k] <= src_l[SAMPLE_W*k +: SAMPLE_W];
               snap_r[k] <= src_r[SAMPLE_W*k +: SAMPLE_W];
               snap_g[k] <= gain[GAIN_W*k +: GAIN_W];
            end
         end
         if (state == ST_ACC) ch <= ch + CH_W'(1);
         // Outputs load at the end of SAT so data and strobe appear together in OUT.
         if (state == ST_SAT) begin
            left       <= mix_l;
            right      <= mix_r;
            sample_stb <= 1'b1;
         end
      end
   end

   mix_mac #(.ACC_W(ACC_W)) u_mac_l (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state == ST_CAPT),
      .en      (state == ST_ACC),
      .sample  (snap_l[ch]),
      .gain    (snap_g[ch]),
      .acc     (acc_l)
   );

   mix_mac #(.ACC_W(ACC_W)) u_mac_r (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state == ST_CAPT),
      .en      (state == ST_ACC),
      .sample  (snap_r[ch]),
      .gain    (snap_g[ch]),
      .acc     (acc_r)
   );

   // Arithmetic shift floors toward -inf; only the shifted value is clamped.
   assign sh_l  = $signed(acc_l) >>> GAIN_SH;
   assign sh_r  = $signed(acc_r) >>> GAIN_SH;
   assign mix_l = snap_mute ? 16'h0000 : sat16(32'(sh_l));
   assign mix_r = snap_mute ? 16'h0000 : sat16(32'(sh_r));

endmodule
